axi_stream_burst_writer: RTL and testbench
==========================================

# axi_stream_burst_writer

Upstream feeder for the PCIe write path. Converts an AXI-Stream of DW-bit beats into fixed-length AXI4 INCR write bursts aimed at a host ring buffer. Addresses wrap inside the ring. The number of bursts awaiting a write response is bounded, and sent/acknowledged burst counts are reported. Its AXI4 master write channels connect directly to the PCIe bridge slave (or its simulation model).

## Interface
Parameters:
- DW, 512, data width in bits (power of 2, ≥ 32)
- AW, 64, address width
- BURST_BEATS, 64, beats per burst, 1..256; AWLEN = BURST_BEATS-1
- MAX_OUTSTANDING, 8, maximum AW-issued-but-not-B-acknowledged bursts, 1..255

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- run  in  1  level; 1 = issue bursts, 0 = stop after the current burst
- base_addr  in  AW  ring base, BURST_BYTES-aligned; sampled on the IDLE→ADDR transition
- ring_bursts  in  32  ring size in bursts (0 is treated as 1); sampled with base_addr
- s_axis_tdata  in  DW  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- M_AXI_AWADDR  out  AW  burst address
- M_AXI_AWLEN  out  8  constant BURST_BEATS-1
- M_AXI_AWSIZE  out  3  constant log2(DW/8)
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR)
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  DW  = s_axis_tdata
- M_AXI_WSTRB  out  DW/8  all ones
- M_AXI_WVALID  out  1
- M_AXI_WLAST  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- bursts_sent  out  32  count of AW handshakes
- bursts_ackd  out  32  count of B handshakes
- bresp_err  out  1  sticky; set when a non-OKAY BRESP is received (see Configuration)

## Operation
- BURST_BYTES = BURST_BEATS·DW/8.
- The FSM has three states: IDLE, ADDR, DATA.
  - IDLE: if run=1, latch base_addr and ring_bursts, clear the ring index, then go to ADDR.
  - ADDR: hold AWVALID=1 while outstanding < MAX_OUTSTANDING (and no halt, see Configuration).
    - On AW handshake: bursts_sent += 1, then go to DATA.
    - If run=0 on entry to ADDR, go to IDLE without issuing.
  - DATA: WVALID = s_axis_tvalid and s_axis_tready = M_AXI_WREADY. Both are 0 in every other state.
    - Beat counter runs 0..BURST_BEATS-1. WLAST=1 when the counter is at BURST_BEATS-1.
    - On the handshake of the WLAST beat: ring index += 1, wrapping to 0 when it reaches ring_bursts. Then go to ADDR if run=1, otherwise IDLE.
- AWADDR = latched base + ring_index·BURST_BYTES, held stable while AWVALID=1.
- outstanding = bursts_sent − bursts_ackd, computed as 32-bit modular arithmetic. An AW handshake and a B handshake in the same cycle cancel.
- BREADY=1 whenever resetn=1. bursts_ackd increments on every B handshake, in every state including IDLE.
- The block never issues AW for burst N+1 before the WLAST of burst N. The W stream never precedes its AW.

## Timing
- Reset values: AWVALID=0, WVALID=0, WLAST=0, s_axis_tready=0, BREADY=0, bursts_sent=0, bursts_ackd=0, bresp_err=0, AWADDR=0, state=IDLE.
- run=1 sampled in IDLE at cycle t gives AWVALID=1 at t+1, provided the outstanding limit allows it.
- AW handshake at cycle t: DATA from t+1. The first W beat can handshake at t+1.
- Throughput: one dead cycle (ADDR) between bursts. With AWREADY, WREADY and tvalid held high, a 64-beat burst takes 65 cycles.
- Outstanding at the limit: stay in ADDR with AWVALID=0. AWVALID rises on the cycle after the B handshake that frees a slot.
- Once AWVALID is asserted it is held, with AWADDR stable, until AWREADY, even if run falls.
- A W-channel stall (tvalid=0 or WREADY=0) freezes the beat counter. No timeout.
- resetn=0 mid-burst aborts immediately. All state and counters return to reset values on the next edge, and no partial burst is completed.

## Configuration
- Macro AXI_BURST_WRITER_BRESP_HALT_EN.
- Defined:
  - A non-OKAY BRESP sets bresp_err.
  - While bresp_err=1, ADDR issues no further AW (the FSM waits in ADDR). If run=0, the FSM returns to IDLE.
  - Only reset clears bresp_err.
- Undefined: bresp_err is tied to 0, BRESP is ignored, and the halt logic is absent.

## Test plan
- BURST_BEATS=4, ring_bursts=3, base=0x1000, DW=512, run=1, stream always valid, slave always ready -> AWADDR sequence 0x1000, 0x1100, 0x1200, 0x1000. WLAST on every 4th beat. bursts_sent = bursts_ackd after drain.
- MAX_OUTSTANDING=2, BVALID held low -> exactly 2 AW handshakes, then AWVALID=0 and tready=0. Releasing one B -> third AWVALID on the next cycle.
- Random tvalid/WREADY gaps (~30% duty) over 10 bursts -> beat order preserved, WLAST count = 10, no beat lost or duplicated.
- run dropped during beat 2 of 4 -> burst completes, FSM returns to IDLE, no further AWVALID. Raising run again -> AWADDR restarts at base.
- resetn=0 asserted mid-burst -> all outputs at reset values on the next cycle, counters = 0.
- With AXI_BURST_WRITER_BRESP_HALT_EN, BRESP=2'b10 on burst 1 -> bresp_err=1 and no AW for burst 3. Without the macro -> bresp_err stays 0 and traffic continues.

Source files
------------

// File: rtl/axi_stream_burst_writer.sv
// ---------------------------------------------------------------------------
// axi_stream_burst_writer
//
// Turns an AXI-Stream of DW-bit beats into fixed-length AXI4 INCR write
// bursts aimed at a host ring buffer. Burst addresses step by one burst
// size and wrap back to the ring base after ring_bursts bursts. The number
// of bursts whose AW has been accepted but whose B response has not yet
// arrived is capped at MAX_OUTSTANDING.
//
// Optional feature macro: AXI_BURST_WRITER_BRESP_HALT_EN
//   Defined   : a non-OKAY BRESP sets the sticky bresp_err, and no new AW is
//               issued until reset.
//   Undefined : BRESP is ignored and bresp_err is tied to 0.
//
// Ports
//   clk, resetn         clock; synchronous active-low reset
//   run                 1 = keep issuing bursts, 0 = stop after current one
//   base_addr           ring base, latched when leaving IDLE
//   ring_bursts         ring size in bursts (0 behaves as 1), latched with base
//   s_axis_*            input stream (tdata / tvalid / tready)
//   M_AXI_AW*           write address channel (master)
//   M_AXI_W*            write data channel (master)
//   M_AXI_B*            write response channel (master)
//   bursts_sent         number of AW handshakes since reset
//   bursts_ackd         number of B handshakes since reset
//   bresp_err           sticky error flag (see macro above)
// ---------------------------------------------------------------------------
module axi_stream_burst_writer #(
  parameter int DW              = 512,
  parameter int AW              = 64,
  parameter int BURST_BEATS     = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic [AW-1:0]   base_addr,
  input  logic [31:0]     ring_bursts,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_WLAST,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [31:0]     bursts_sent,
  output logic [31:0]     bursts_ackd,
  output logic            bresp_err
);

  localparam int              BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
  localparam logic [AW-1:0]   BURST_BYTES = AW'(BURST_BEATS * (DW / 8));
  localparam logic [31:0]     MAX_OUT     = 32'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       base_q, base_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [31:0]         ring_q, ring_d;
  logic [31:0]         ring_idx_q, ring_idx_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                aw_hold_q, aw_hold_d;
  logic [31:0]         sent_q, sent_d;
  logic [31:0]         ackd_q, ackd_d;

  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                halt;
  logic [31:0]         outstanding;
  logic [31:0]         ring_eff;
  logic [31:0]         ring_next;

  // BREADY follows reset directly: low while in reset, high otherwise.
  assign M_AXI_BREADY = resetn;
  assign b_hs         = M_AXI_BVALID && M_AXI_BREADY;

  // Modular difference; a simultaneous AW and B handshake cancel out.
  assign outstanding  = sent_q - ackd_q;
  assign ring_eff     = (ring_q == 32'd0) ? 32'd1 : ring_q;
  assign ring_next    = ring_idx_q + 32'd1;

  // ---------------------------------------------------------------------
  // Optional BRESP error halt
  // ---------------------------------------------------------------------
`ifdef AXI_BURST_WRITER_BRESP_HALT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (b_hs && (M_AXI_BRESP != 2'b00)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign halt      = err_q;
  assign bresp_err = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^M_AXI_BRESP;
  assign halt         = 1'b0;
  assign bresp_err    = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    addr_d        = addr_q;
    ring_d        = ring_q;
    ring_idx_d    = ring_idx_q;
    beat_d        = beat_q;
    aw_hold_d     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    s_axis_tready = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          base_d     = base_addr;
          addr_d     = base_addr;
          ring_d     = ring_bursts;
          ring_idx_d = 32'd0;
          beat_d     = '0;
          state_d    = S_ADDR;
        end
      end

      S_ADDR: begin
        // An AW already presented must stay up until accepted, regardless
        // of run, the outstanding limit or the error halt.
        if (aw_hold_q) begin
          M_AXI_AWVALID = 1'b1;
        end else if (!run) begin
          state_d = S_IDLE;
        end else begin
          M_AXI_AWVALID = (outstanding < MAX_OUT) && !halt;
        end

        aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
        aw_hold_d = M_AXI_AWVALID && !M_AXI_AWREADY;
        if (aw_hs) begin
          beat_d  = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        M_AXI_WVALID  = s_axis_tvalid;
        s_axis_tready = M_AXI_WREADY;
        M_AXI_WLAST   = (beat_q == LAST_BEAT);
        w_hs          = s_axis_tvalid && M_AXI_WREADY;
        if (w_hs) begin
          if (M_AXI_WLAST) begin
            beat_d = '0;
            if (ring_next >= ring_eff) begin
              ring_idx_d = 32'd0;
              addr_d     = base_q;
            end else begin
              ring_idx_d = ring_next;
              addr_d     = addr_q + BURST_BYTES;
            end
            state_d = run ? S_ADDR : S_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    sent_d = sent_q + {31'd0, aw_hs};
    ackd_d = ackd_q + {31'd0, b_hs};
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      ring_q     <= 32'd0;
      ring_idx_q <= 32'd0;
      beat_q     <= '0;
      aw_hold_q  <= 1'b0;
      sent_q     <= 32'd0;
      ackd_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      ring_q     <= ring_d;
      ring_idx_q <= ring_idx_d;
      beat_q     <= beat_d;
      aw_hold_q  <= aw_hold_d;
      sent_q     <= sent_d;
      ackd_q     <= ackd_d;
    end
  end

  // ---------------------------------------------------------------------
  // Fixed and pass-through outputs
  // ---------------------------------------------------------------------
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
  assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = s_axis_tdata;
  assign bursts_sent   = sent_q;
  assign bursts_ackd   = ackd_q;

  genvar gi;
  generate
    for (gi = 0; gi < DW / 8; gi++) begin : g_wstrb
      assign M_AXI_WSTRB[gi] = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_burst_writer
//
// Directed sequence with randomized handshakes. A reference model of the
// ring addressing, beat ordering and burst/response accounting is kept in
// plain counters and checked every cycle on the falling clock edge.
// Honours AXI_BURST_WRITER_BRESP_HALT_EN for the error-halt expectations.
// ---------------------------------------------------------------------------
module tb_axi_stream_burst_writer;

  localparam int DW    = 512;
  localparam int AW    = 64;
  localparam int BEATS = 4;
  localparam int MAXO  = 2;
  localparam int BB    = BEATS * DW / 8;   // bytes per burst

  logic            clk = 1'b0;
  logic            resetn;
  logic            run;
  logic [AW-1:0]   base_addr;
  logic [31:0]     ring_bursts;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [AW-1:0]   M_AXI_AWADDR;
  logic [7:0]      M_AXI_AWLEN;
  logic [2:0]      M_AXI_AWSIZE;
  logic [1:0]      M_AXI_AWBURST;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID;
  logic            M_AXI_WLAST;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic [31:0]     bursts_sent;
  logic [31:0]     bursts_ackd;
  logic            bresp_err;

  axi_stream_burst_writer #(
    .DW(DW), .AW(AW), .BURST_BEATS(BEATS), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .resetn(resetn), .run(run),
    .base_addr(base_addr), .ring_bursts(ring_bursts),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .bursts_sent(bursts_sent), .bursts_ackd(bursts_ackd),
    .bresp_err(bresp_err)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] salt;

  // Stimulus knobs (percent probabilities)
  int p_tv, p_wr, p_aw, p_b;
  int b_owed, b_credit, b_issued;
  bit b_done;
  bit err_inject;

  // Reference model
  int          m_sent, m_ackd, m_wlast, m_idx, m_beat, w_idx, s_idx;
  bit          m_err;
  logic [63:0] m_base;
  int unsigned m_ring;
  bit          prev_aw_pend;
  logic [63:0] prev_addr;
  bit          chk_gap;
  int          last_aw_cyc;
  logic [63:0] aw_log[$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] data_of(input int idx);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) begin
      d[k*32 +: 32] = (32'(idx) * 32'h9E3779B9) ^ salt ^ 32'(k);
    end
    return d;
  endfunction

  function automatic logic [63:0] exp_addr();
    int unsigned ring_eff;
    ring_eff = (m_ring == 0) ? 1 : m_ring;
    return m_base + 64'(unsigned'(m_idx) % ring_eff) * 64'(BB);
  endfunction

  // Falling-edge monitor: compare DUT against the model, then account for
  // the handshakes that the coming rising edge will complete.
  task automatic monitor();
    logic aw_hs, w_hs, s_hs, b_hs;
    cyc++;
    if (!resetn) begin
      prev_aw_pend = 1'b0;
      return;
    end
    aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    s_hs  = s_axis_tvalid && s_axis_tready;
    b_hs  = M_AXI_BVALID && M_AXI_BREADY;

    check("bready", M_AXI_BREADY, 1'b1);
    check("bursts_sent", bursts_sent, 32'(m_sent));
    check("bursts_ackd", bursts_ackd, 32'(m_ackd));
    check("bresp_err", bresp_err, m_err);
    check("stream_eq_w_hs", s_hs, w_hs);
    check("aw_while_burst_open", M_AXI_AWVALID && (m_sent != m_wlast), 1'b0);
    check("w_without_aw", M_AXI_WVALID && (m_sent == m_wlast), 1'b0);
    check("aw_over_limit", M_AXI_AWVALID && ((m_sent - m_ackd) >= MAXO), 1'b0);
    check("aw_without_run", M_AXI_AWVALID && !run && !prev_aw_pend, 1'b0);
`ifdef AXI_BURST_WRITER_BRESP_HALT_EN
    check("aw_after_err", M_AXI_AWVALID && m_err && !prev_aw_pend, 1'b0);
`endif
    if (prev_aw_pend) begin
      check("aw_hold", M_AXI_AWVALID, 1'b1);
      check("aw_addr_stable", M_AXI_AWADDR, prev_addr);
    end
    if (M_AXI_AWVALID) begin
      check("awaddr", M_AXI_AWADDR, exp_addr());
    end
    if (w_hs) begin
      check("wdata", M_AXI_WDATA, data_of(w_idx));
      check("wlast", M_AXI_WLAST, m_beat == BEATS - 1);
      check("wstrb", M_AXI_WSTRB, {(DW/8){1'b1}});
    end

    if (aw_hs) begin
      if (chk_gap && m_idx > 0) begin
        check("aw_gap", 32'(cyc - last_aw_cyc), 32'd5);
      end
      last_aw_cyc = cyc;
      aw_log.push_back(M_AXI_AWADDR);
      m_sent++;
      m_idx++;
    end
    if (s_hs) s_idx++;
    if (w_hs) begin
      w_idx++;
      if (m_beat == BEATS - 1) begin
        m_beat = 0;
        m_wlast++;
        b_owed++;
      end else begin
        m_beat++;
      end
    end
    if (b_hs) begin
      m_ackd++;
      b_done = 1'b1;
`ifdef AXI_BURST_WRITER_BRESP_HALT_EN
      if (M_AXI_BRESP != 2'b00) m_err = 1'b1;
`endif
    end
    prev_aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
    prev_addr    = M_AXI_AWADDR;
  endtask

  // Drive the slave side and stream after the rising edge.
  task automatic drive();
    s_axis_tvalid = ($urandom_range(0, 99) < p_tv);
    s_axis_tdata  = data_of(s_idx);
    M_AXI_WREADY  = ($urandom_range(0, 99) < p_wr);
    M_AXI_AWREADY = ($urandom_range(0, 99) < p_aw);
    if (b_done) begin
      M_AXI_BVALID = 1'b0;
      b_done       = 1'b0;
    end
    if (!M_AXI_BVALID && b_owed > 0 && b_credit > 0 && ($urandom_range(0, 99) < p_b)) begin
      M_AXI_BVALID = 1'b1;
      M_AXI_BRESP  = (err_inject && b_issued == 1) ? 2'b10 : 2'b00;
      b_issued++;
      b_owed--;
      b_credit--;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic set_rates(input int tv, input int wr, input int aw, input int b);
    p_tv = tv; p_wr = wr; p_aw = aw; p_b = b;
  endtask

  task automatic start_run(input logic [63:0] base, input int unsigned ring);
    base_addr   = base;
    ring_bursts = ring;
    m_base      = base;
    m_ring      = ring;
    m_idx       = 0;
    run         = 1'b1;
  endtask

  task automatic stop_and_drain(input string tag);
    int n;
    run = 1'b0;
    n = 0;
    while ((m_sent != m_wlast || M_AXI_AWVALID) && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    n = 0;
    while (m_ackd != m_sent && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_drained_ackd"}, bursts_ackd, 32'(m_sent));
  endtask

  task automatic model_reset();
    m_sent = 0; m_ackd = 0; m_wlast = 0; m_idx = 0; m_beat = 0;
    w_idx = 0; s_idx = 0; m_err = 1'b0;
    b_owed = 0; b_issued = 0; b_done = 1'b0;
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    prev_aw_pend = 1'b0;
    aw_log.delete();
    run = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_awvalid"}, M_AXI_AWVALID, 1'b0);
    check({tag, "_wvalid"}, M_AXI_WVALID, 1'b0);
    check({tag, "_wlast"}, M_AXI_WLAST, 1'b0);
    check({tag, "_tready"}, s_axis_tready, 1'b0);
    check({tag, "_bready"}, M_AXI_BREADY, 1'b0);
    check({tag, "_sent"}, bursts_sent, 32'd0);
    check({tag, "_ackd"}, bursts_ackd, 32'd0);
    check({tag, "_err"}, bresp_err, 1'b0);
    check({tag, "_awaddr"}, M_AXI_AWADDR, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, a0, wl0;
    salt          = $urandom;
    resetn        = 1'b0;
    run           = 1'b0;
    base_addr     = '0;
    ring_bursts   = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    chk_gap       = 1'b0;
    err_inject    = 1'b0;
    b_credit      = 1000000;
    last_aw_cyc   = 0;
    m_base        = '0;
    m_ring        = 0;
    prev_addr     = '0;
    set_rates(100, 100, 100, 100);
    model_reset();

    // Power-on reset
    repeat (3) tick();
    check_reset_state("por");
    check("awlen", M_AXI_AWLEN, 8'd3);
    check("awsize", M_AXI_AWSIZE, 3'd6);
    check("awburst", M_AXI_AWBURST, 2'b01);
    resetn = 1'b1;
    tick();

    // Ring walk, everything ready: addresses wrap after 3 bursts
    chk_gap = 1'b1;
    start_run(64'h1000, 3);
    tick();
    check("run_to_awvalid", M_AXI_AWVALID, 1'b1);
    n = 0;
    while (m_sent < 4 && n < 200) begin tick(); n++; end
    check("ring_walk_progress", bursts_sent, 32'd4);
    stop_and_drain("ring_walk");
    chk_gap = 1'b0;
    check("ring_addr0", aw_log[0], 64'h1000);
    check("ring_addr1", aw_log[1], 64'h1100);
    check("ring_addr2", aw_log[2], 64'h1200);
    check("ring_addr3", aw_log[3], 64'h1000);
    $display("ring walk: sent=%0d ackd=%0d", bursts_sent, bursts_ackd);

    // Outstanding limit: no B responses -> exactly MAXO bursts go out
    s0 = m_sent;
    b_credit = 0;
    start_run(64'h8000, 8);
    repeat (30) tick();
    check("limit_aw_count", bursts_sent - 32'(s0), 32'(MAXO));
    check("limit_awvalid", M_AXI_AWVALID, 1'b0);
    check("limit_tready", s_axis_tready, 1'b0);
    a0 = m_ackd;
    b_credit = 1;
    n = 0;
    while (m_ackd == a0 && n < 20) begin tick(); n++; end
    check("limit_b_released", 32'(m_ackd - a0), 32'd1);
    check("limit_aw_after_b", M_AXI_AWVALID, 1'b1);
    b_credit = 1000000;
    stop_and_drain("limit");
    $display("outstanding limit: sent=%0d ackd=%0d", bursts_sent, bursts_ackd);

    // Random W/AW/B gaps over 10 bursts with a random ring size
    set_rates(70, 70, 70, 50);
    s0  = m_sent;
    wl0 = m_wlast;
    start_run(64'h2_0000 + 64'($urandom_range(0, 15)) * 64'(BB), $urandom_range(0, 4));
    n = 0;
    while (m_sent < s0 + 10 && n < 3000) begin tick(); n++; end
    stop_and_drain("random");
    check("random_bursts", bursts_sent - 32'(s0), 32'd10);
    check("random_wlast_count", 32'(m_wlast - wl0), 32'd10);
    $display("random gaps: ring=%0d bursts=%0d beats=%0d", m_ring, m_wlast - wl0, w_idx);

    // run dropped during beat 2 of the second burst, then restarted
    set_rates(100, 100, 100, 100);
    s0 = m_sent;
    start_run(64'h4000, 3);
    n = 0;
    while (!(m_sent == s0 + 2 && m_beat == 1) && n < 200) begin tick(); n++; end
    run = 1'b0;
    repeat (15) tick();
    check("drop_sent", bursts_sent - 32'(s0), 32'd2);
    check("drop_burst_done", 32'(m_wlast), 32'(m_sent));
    check("drop_awvalid", M_AXI_AWVALID, 1'b0);
    start_run(64'h4000, 3);
    n = 0;
    while (m_sent < s0 + 3 && n < 50) begin tick(); n++; end
    check("restart_at_base", aw_log[aw_log.size() - 1], 64'h4000);
    stop_and_drain("restart");
    $display("run drop/restart: sent=%0d", bursts_sent);

    // Reset in the middle of a burst
    start_run(64'h6000, 2);
    n = 0;
    while (!(m_sent >= 1 && m_beat == 2) && n < 200) begin tick(); n++; end
    resetn = 1'b0;
    tick();
    check_reset_state("midreset");
    model_reset();
    tick();
    resetn = 1'b1;
    tick();
    $display("mid-burst reset: sent=%0d ackd=%0d", bursts_sent, bursts_ackd);

    // Error response on the second burst's B
    err_inject = 1'b1;
    start_run(64'h9000, 4);
    repeat (40) tick();
`ifdef AXI_BURST_WRITER_BRESP_HALT_EN
    check("halt_err_set", bresp_err, 1'b1);
    check("halt_sent", bursts_sent, 32'd3);
    check("halt_awvalid", M_AXI_AWVALID, 1'b0);
`else
    check("noerr_flag", bresp_err, 1'b0);
    check("noerr_traffic", bursts_sent > 32'd3, 1'b1);
`endif
    stop_and_drain("bresp");
    err_inject = 1'b0;
    $display("bresp test: sent=%0d err=%0d", bursts_sent, bresp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
